// File: rtl/mant_mul_seq_if.sv
// Handshake bundle for the significand multiplier: operand side (valid/ready
// plus the two significands) and result side (valid/ready plus product).
interface mant_mul_seq_if #(
  parameter int WIDTH = 24
);
  logic               i_valid;
  logic               o_ready;
  logic [WIDTH-1:0]   i_a;
  logic [WIDTH-1:0]   i_b;
  logic               o_valid;
  logic               i_ready;
  logic [2*WIDTH-1:0] o_product;
  logic               o_msb;
  logic               o_busy;

  // Upstream/downstream environment side
  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_product, o_msb, o_busy
  );

  // Multiplier side
  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_product, o_msb, o_busy
  );
endinterface

// File: rtl/mant_mul_seq.sv
// Iterative radix-2 shift-and-add multiplier for single-precision significands.
// One partial product per cycle; the 2*WIDTH-bit raw product feeds the
// normalizer. Zero operands can short-circuit the iteration.
module mant_mul_seq #(
  parameter int WIDTH     = 24,
  parameter int ZERO_SKIP = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mant_mul_seq_if.slave  io_bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_mcand;   // multiplicand, shifted left each step
  logic [WIDTH-1:0] r_mplier; // multiplier, shifted right each step
  logic [PW-1:0]   r_acc;     // running product
  logic [CW-1:0]   r_cnt;
  logic            r_ready;
  logic            r_busy;
  logic            r_valid;

  logic            w_zero_op;
  logic [PW-1:0]   w_addend;
  logic            w_last;

  // Step datapath: conditional addend, zero-operand detect, final-step detect
  always_comb begin
    w_zero_op = (ZERO_SKIP != 0) && ((io_bus.i_a == '0) || (io_bus.i_b == '0));
    w_addend  = r_mplier[0] ? r_mcand : '0;
    w_last    = (r_cnt == CW'(WIDTH - 1));
  end

  // Control FSM with registered status flags and iteration datapath
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // r_ready is high throughout IDLE, so i_valid alone means accept
          if (io_bus.i_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, io_bus.i_a};
            r_mplier <= io_bus.i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            if (w_zero_op) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_acc    <= r_acc + w_addend;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          // Result holds until the normalizer takes it; no accept this edge
          if (io_bus.i_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.o_ready   = r_ready;
  assign io_bus.o_busy    = r_busy;
  assign io_bus.o_valid   = r_valid;
  assign io_bus.o_product = r_acc;
  assign io_bus.o_msb     = r_acc[PW-1];

endmodule

// File: tb/tb_mant_mul_seq.sv
// Scoreboard bench for mant_mul_seq: accepts push a plain-arithmetic expected
// product and latency; a negedge monitor checks each presented result.
module tb_mant_mul_seq;

  localparam int W = 24;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mant_mul_seq_if #(.WIDTH(W)) bus ();
  mant_mul_seq_if #(.WIDTH(W)) bus_nz ();

  mant_mul_seq #(.WIDTH(W), .ZERO_SKIP(1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  mant_mul_seq #(.WIDTH(W), .ZERO_SKIP(0)) dut_nz (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_p;
    int             acc_edge;  // number of the accepting clock edge
    int             lat;       // edges after the accept edge until o_valid is seen
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // i_ready driver: fixed level or random stalls
  bit rand_ready = 1'b0;
  bit rdy_fixed  = 1'b1;
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) bus.i_ready = ($urandom_range(0, 3) != 0);
      else            bus.i_ready = rdy_fixed;
    end
  end

  // Monitor / scoreboard
  initial begin
    bit             prev_valid = 1'b0;
    bit             prev_stall = 1'b0;
    bit             post_hs    = 1'b0;
    logic [2*W-1:0] prev_prod  = '0;
    exp_t           e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        post_hs    = 1'b0;
      end else begin
        chk({bus.o_ready, bus.o_busy, bus.o_valid} inside {3'b100, 3'b010, 3'b001},
            "state_flags", {61'd0, bus.o_ready, bus.o_busy, bus.o_valid}, 64'd0);
        chk(bus.o_msb == bus.o_product[2*W-1], "msb_bit", 64'(bus.o_msb), 64'(bus.o_product[2*W-1]));
        if (post_hs)
          chk(bus.o_ready && !bus.o_valid, "idle_after_done", {62'd0, bus.o_ready, bus.o_valid}, 64'h2);
        post_hs = 1'b0;
        if (prev_valid && bus.o_valid && prev_stall)
          chk(bus.o_product == prev_prod, "hold_product", 64'(bus.o_product), 64'(prev_prod));
        if (bus.o_valid && !prev_valid) begin
          chk(sb_q.size() > 0, "result_without_accept", 64'(sb_q.size()), 64'd1);
          if (sb_q.size() > 0) begin
            e = sb_q[0];
            chk(bus.o_product == e.exp_p, "product", 64'(bus.o_product), 64'(e.exp_p));
            chk((cyc - e.acc_edge) == e.lat, "latency", 64'(cyc - e.acc_edge), 64'(e.lat));
          end
        end
        if (bus.o_valid && bus.i_ready) begin
          if (sb_q.size() > 0) void'(sb_q.pop_front());
          post_hs = 1'b1;
        end
        if (bus.i_valid && bus.o_ready) begin
          e.a        = bus.i_a;
          e.b        = bus.i_b;
          e.exp_p    = (2*W)'(bus.i_a) * (2*W)'(bus.i_b);
          e.acc_edge = cyc + 1;
          e.lat      = ((bus.i_a == 0) || (bus.i_b == 0)) ? 0 : W;
          sb_q.push_back(e);
        end
        prev_valid = bus.o_valid;
        prev_stall = !bus.i_ready;
        prev_prod  = bus.o_product;
      end
    end
  end

  // Present operands until accepted, then scramble the inputs
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.o_ready) break;
    end
    if (!bus.o_ready) chk(1'b0, "accept_timeout", 64'(bus.o_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_a     = W'($urandom);
    bus.i_b     = W'($urandom);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.o_valid) break;
    end
    if (!bus.o_valid) chk(1'b0, "valid_timeout", 64'(bus.o_valid), 64'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.o_ready) break;
    end
    if (!bus.o_ready) chk(1'b0, "idle_timeout", 64'(bus.o_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_p, input bit exp_msb, input string nm);
    send(a, b);
    wait_valid();
    chk(bus.o_product == exp_p, {nm, "_product"}, 64'(bus.o_product), 64'(exp_p));
    chk(bus.o_msb == exp_msb, {nm, "_msb"}, 64'(bus.o_msb), 64'(exp_msb));
    wait_idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    rst_n          = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_a        = '0;
    bus.i_b        = '0;
    bus_nz.i_valid = 1'b0;
    bus_nz.i_a     = '0;
    bus_nz.i_b     = '0;
    bus_nz.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(bus.o_valid == 1'b0, "rst_valid", 64'(bus.o_valid), 64'd0);
    chk(bus.o_product == '0, "rst_product", 64'(bus.o_product), 64'd0);
    chk(bus.o_msb == 1'b0, "rst_msb", 64'(bus.o_msb), 64'd0);
    chk(bus.o_busy == 1'b0, "rst_busy", 64'(bus.o_busy), 64'd0);
    chk(bus.o_ready == 1'b1, "rst_ready", 64'(bus.o_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed values with spec-given products
    directed(24'hC00000, 24'hC00000, 48'h900000000000, 1'b1, "m1p5x1p5");
    directed(24'h800000, 24'h800000, 48'h400000000000, 1'b0, "m1x1");
    directed(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1, "mmax");
    directed(24'h000000, 24'hABCDEF, 48'h0, 1'b0, "zero_skip");

    // Backpressure: result must hold and no accept may slip in
    rdy_fixed = 1'b0;
    send(24'hC00000, 24'hA00000);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      bus.i_valid = ~bus.i_valid;
      bus.i_a     = W'($urandom);
      @(negedge clk);
      chk(bus.o_product == 48'h780000000000, "bp_product", 64'(bus.o_product), 64'h780000000000);
      chk(bus.o_ready == 1'b0, "bp_ready", 64'(bus.o_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    rdy_fixed   = 1'b1;
    @(posedge clk);
    #1;
    chk(bus.o_ready == 1'b1, "bp_release_ready", 64'(bus.o_ready), 64'd1);
    chk(bus.o_busy == 1'b0, "bp_no_spurious", 64'(bus.o_busy), 64'd0);
    chk(bus.o_valid == 1'b0, "bp_release_valid", 64'(bus.o_valid), 64'd0);
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset during RUN discards the operation
    send(24'hC00000, 24'hC00000);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk(bus.o_busy == 1'b0, "midrst_busy", 64'(bus.o_busy), 64'd0);
    chk(bus.o_valid == 1'b0, "midrst_valid", 64'(bus.o_valid), 64'd0);
    chk(bus.o_product == '0, "midrst_product", 64'(bus.o_product), 64'd0);
    chk(bus.o_ready == 1'b1, "midrst_ready", 64'(bus.o_ready), 64'd1);
    directed(24'h800000, 24'hC00000, 48'h600000000000, 1'b0, "post_rst");

    // Zero operand without the skip path takes the full iteration
    bus_nz.i_a     = 24'h000000;
    bus_nz.i_b     = 24'hABCDEF;
    bus_nz.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_nz.i_valid = 1'b0;
    n = 0;
    while (!bus_nz.o_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n == W, "noskip_latency", 64'(n), 64'(W));
    chk(bus_nz.o_product == '0, "noskip_product", 64'(bus_nz.o_product), 64'd0);
    @(posedge clk);
    #1;

    // Random operands with random downstream stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 15))
        0: ra = '0;
        1: rb = '0;
        2: ra = '1;
        3: rb = 24'h800000;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(ra, rb);
    end
    rand_ready = 1'b0;
    rdy_fixed  = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(sb_q.size() == 0, "drain_results", 64'(sb_q.size()), 64'd0);
    chk(bus.o_ready == 1'b1, "final_idle", 64'(bus.o_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mant_mul_seq.md
Name: mant_mul_seq

Overview:
- Iterative radix-2 shift-and-add unsigned multiplier for the 24-bit significands (hidden bit included) of the two single-precision operands.
- Produces the 48-bit raw product consumed directly by the normalization stage (leading-zero count plus shift).
- Sits upstream of normalization. Decouples from the exponent/sign path via a valid/ready handshake on both sides.

Parameters:
- WIDTH, 24, significand width in bits; product width is 2*WIDTH.
- ZERO_SKIP, 1, when 1 a zero operand bypasses iteration and completes in one cycle.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_valid  input  1  upstream has operands on i_a/i_b
- o_ready  output  1  block can accept operands (high only in IDLE)
- i_a  input  WIDTH  multiplicand significand
- i_b  input  WIDTH  multiplier significand
- o_valid  output  1  o_product holds a completed result
- i_ready  input  1  downstream (normalization) accepts the result
- o_product  output  2*WIDTH  unsigned product i_a*i_b
- o_msb  output  1  o_product[2*WIDTH-1]; tells the normalizer whether product is in [2,4)
- o_busy  output  1  high in RUN

Behaviour:
- Reset:
  - i_rst_n low at a rising edge sets state IDLE.
  - Outputs after reset: o_valid=0, o_product=0, o_msb=0, o_busy=0, o_ready=1.
  - The iteration counter and internal operand registers are cleared.
  - Reset takes priority over every other event, including mid-RUN and DONE; the in-flight operation is discarded with no output.
- States: IDLE, RUN, DONE.
  - o_ready = (state==IDLE).
  - o_busy = (state==RUN).
  - o_valid = (state==DONE).
- IDLE:
  - Accept occurs when i_valid && o_ready at an edge (edge E0).
  - On accept, latch the multiplicand (zero-extended to 2*WIDTH), latch the multiplier, clear the accumulator and set counter=0.
  - If ZERO_SKIP=1 and (i_a==0 or i_b==0): load accumulator=0 and go to DONE, so o_valid is high after E0 (latency 1).
  - Otherwise go to RUN.
- RUN:
  - Each edge: if multiplier[0]==1, accumulator += multiplicand.
  - Then shift multiplicand left by 1, shift multiplier right by 1, and increment the counter.
  - When counter==WIDTH-1 on an edge, that edge performs the final step and moves to DONE.
  - So o_valid rises after edge E_WIDTH, i.e. WIDTH cycles after accept (24 by default).
  - i_valid is ignored in RUN.
- Arithmetic:
  - The accumulator is 2*WIDTH bits and never overflows, since the maximum is (2^WIDTH-1)^2.
  - The result is fully unsigned with no rounding or truncation.
- DONE:
  - o_product is driven from the accumulator register; o_msb is its top bit.
  - Both hold stable while i_ready=0, for an unbounded time.
  - On an edge with i_ready=1, go to IDLE.
  - o_product keeps its last value after leaving DONE; it is only meaningful while o_valid=1.
  - No new accept occurs in the same cycle as the DONE→IDLE transition. Minimum issue interval is WIDTH+2 cycles for non-zero operands, 2 cycles for zero-skip.
- Operand capture: i_a and i_b are sampled only at the accept edge. Changes afterwards have no effect.
- Simultaneous events:
  - i_valid high during DONE is not accepted; o_ready=0.
  - i_ready high outside DONE is ignored.
- No combinational path from any input to any output. All outputs are registered or decoded from state.

Test Plan:
- 1.5×1.5: i_a=i_b=24'hC00000, i_ready=1 → o_valid rises exactly 24 cycles after accept, o_product=48'h900000000000, o_msb=1, then returns to IDLE with o_ready=1 one cycle later.
- 1.0×1.0 and max:
  - 24'h800000×24'h800000 → 48'h400000000000, o_msb=0.
  - 24'hFFFFFF×24'hFFFFFF → 48'hFFFFFE000001, o_msb=1.
- Zero skip: i_a=0, i_b=24'hABCDEF → o_valid one cycle after accept with o_product=0.
  - With ZERO_SKIP=0, the same result arrives after 24 cycles.
- Backpressure: complete 24'hC00000×24'hA00000, hold i_ready=0 for 5 cycles while toggling i_valid and i_a → o_product stays 48'h780000000000 and o_ready stays 0. Raising i_ready gives IDLE on the next edge, with no spurious accept.
- Reset mid-operation: assert i_rst_n=0 for one edge at RUN cycle 10 → next cycle o_busy=0, o_valid=0, o_product=0, o_ready=1. A following 24'h800000×24'hC00000 yields 48'h600000000000.
- Random: 1000 random operand pairs with random i_ready stalls → every product matches the reference multiply. Verify o_ready=1 only in IDLE and one result per accept.
